// File: rtl/reg_file_wb.sv
// reg_file_wb: 32 x 32-bit register file with write-back bypass and a
// load scoreboard (busy vector + pending count) that raises a stall when a
// read operand is waiting on an outstanding load.
//
// Ports:
//   clk       - single clock, all state updates on its rising edge
//   rstn      - asynchronous active-low reset
//   RFWr      - write-back enable
//   A3        - write-back destination register
//   WD        - write-back data
//   WDSel     - write-back source tag (00 ALU, 01 load, 10 PC+4, 11 PC+off)
//   A1, A2    - read addresses
//   RD1, RD2  - combinational read data (with same-cycle write bypass)
//   ld_issue  - a load targeting ld_rd issues this cycle
//   ld_rd     - destination register of the issuing load
//   stall     - a read operand is waiting on an outstanding load
//   pend_cnt  - number of registers currently marked load-pending
module reg_file_wb (
    input  logic        clk,
    input  logic        rstn,
    input  logic        RFWr,
    input  logic [4:0]  A3,
    input  logic [31:0] WD,
    input  logic [1:0]  WDSel,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    output logic [31:0] RD1,
    output logic [31:0] RD2,
    input  logic        ld_issue,
    input  logic [4:0]  ld_rd,
    output logic        stall,
    output logic [5:0]  pend_cnt
);

    logic [31:0] r_regs [32];
    logic [31:0] r_busy;
    logic [5:0]  r_pend_cnt;

    logic        w_wr;
    logic        w_ld_wb;
    logic        w_set;
    logic        w_inc;
    logic        w_dec;
    logic [31:0] w_busy_nxt;
    logic        w_stall1;
    logic        w_stall2;

    assign w_wr    = RFWr && (A3 != 5'd0);
    assign w_ld_wb = w_wr && (WDSel == 2'b01);
    assign w_set   = ld_issue && (ld_rd != 5'd0);

    // Counter tracks popcount(busy) incrementally: a set only counts when
    // the bit was clear, a clear only counts when the bit was set and is
    // not simultaneously being re-set (set wins on the same register).
    assign w_inc = w_set && !r_busy[ld_rd];
    assign w_dec = w_ld_wb && r_busy[A3] && !(w_set && (ld_rd == A3));

    always_comb begin
        w_busy_nxt = r_busy;
        if (w_ld_wb) begin
            w_busy_nxt[A3] = 1'b0;
        end
        if (w_set) begin
            w_busy_nxt[ld_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr) begin
            r_regs[A3] <= WD;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_busy     <= '0;
            r_pend_cnt <= '0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_pend_cnt <= r_pend_cnt + {5'd0, w_inc} - {5'd0, w_dec};
        end
    end

    // Register 0 is forced to zero after the bypass so it also wins over it.
    always_comb begin
        RD1 = r_regs[A1];
        if (w_wr && (A1 == A3)) begin
            RD1 = WD;
        end
        if (A1 == 5'd0) begin
            RD1 = '0;
        end
    end

    always_comb begin
        RD2 = r_regs[A2];
        if (w_wr && (A2 == A3)) begin
            RD2 = WD;
        end
        if (A2 == 5'd0) begin
            RD2 = '0;
        end
    end

    // Only a same-cycle load write-back releases a port from the stall;
    // a non-load write to a busy register still stalls.
    assign w_stall1 = (A1 != 5'd0) && r_busy[A1] && !(w_ld_wb && (A1 == A3));
    assign w_stall2 = (A2 != 5'd0) && r_busy[A2] && !(w_ld_wb && (A2 == A3));
    assign stall    = w_stall1 || w_stall2;
    assign pend_cnt = r_pend_cnt;

endmodule
